au_result_stage: RTL and testbench



---
 rtl/au_pkg.sv | 23 ++
 rtl/au_fifo.sv | 55 +++++
 rtl/au_result_stage.sv | 95 +++++++++
 tb/tb_au_result_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// Shared types and constants for the arithmetic-unit result path.
package au_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } au_op_e;

  // Primary result reported for a division by zero.
  localparam logic [7:0] DIV0_RES = 8'hFF;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] res;
    logic [7:0] rem;
    logic       err;
  } au_result_t;

  localparam int unsigned AU_RESULT_W = $bits(au_result_t);

endpackage

// File: rtl/au_fifo.sv
// Generic DEPTH x W synchronous FIFO. Read data is forced to zero while
// empty so downstream never observes stale entries.
module au_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push  = i_wr_en && !w_full;
  assign w_pop   = i_rd_en && !w_empty;

  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset discards all entries by clearing both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are unobservable until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/au_result_stage.sv
// Collapses the arithmetic unit's per-opcode result buses into one tagged
// entry, buffers it behind a valid/ready FIFO and counts divide-by-zero ops.
module au_result_stage
  import au_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [7:0]       o,
  input  logic [7:0]       o1,
  input  logic [7:0]       o2,
  input  logic [7:0]       o3,
  input  logic [7:0]       o4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [7:0]       out_res,
  output logic [7:0]       out_rem,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  au_result_t             w_entry;
  au_result_t             w_head;
  logic [AU_RESULT_W-1:0] w_rd_data;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic [CNT_W-1:0]       r_err_cnt;

  // Select the result bus for the presented opcode and tag it.
  always_comb begin
    w_entry     = '0;
    w_entry.op  = op;
    case (au_op_e'(op))
      OP_ADD: w_entry.res = o;
      OP_SUB: w_entry.res = o1;
      OP_MUL: w_entry.res = o2;
      OP_DIV: begin
        if (b == 4'h0) begin
          w_entry.res = DIV0_RES;
          w_entry.rem = {4'h0, a};
          w_entry.err = 1'b1;
        end else begin
          w_entry.res = o3;
          w_entry.rem = o4;
        end
      end
      default: w_entry = '0;
    endcase
  end

  // in_ready depends only on registered FIFO state, never on out_ready.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  au_fifo #(
    .DEPTH (DEPTH),
    .W     (AU_RESULT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (in_valid),
    .i_wr_data (w_entry),
    .i_rd_en   (out_ready),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_head    = au_result_t'(w_rd_data);
  assign out_valid = !w_empty;
  assign out_op    = w_head.op;
  assign out_res   = w_head.res;
  assign out_rem   = w_head.rem;
  assign out_err   = w_head.err;
  assign err_cnt   = r_err_cnt;

  // Saturating count of accepted divide-by-zero entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_push && w_entry.err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_au_result_stage.sv
// Randomised and directed bench for au_result_stage against a queue model.
module tb_au_result_stage;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = '0;
  logic [3:0]       a = '0;
  logic [3:0]       b = '0;
  logic [7:0]       o = '0, o1 = '0, o2 = '0, o3 = '0, o4 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_op;
  logic [7:0]       out_res;
  logic [7:0]       out_rem;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;

  au_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .o(o), .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_res(out_res), .out_rem(out_rem), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] res;
    logic [7:0] rem;
    logic       err;
  } exp_t;

  exp_t       q[$];
  int         m_cnt;
  logic [7:0] dut_popped[$];
  logic [7:0] mdl_popped[$];
  int         total = 0;
  int         bad = 0;

  // Expected entry straight from the arithmetic meaning of each opcode.
  function automatic exp_t model_entry(logic [1:0] f_op, logic [3:0] fa, logic [3:0] fb);
    exp_t e;
    int ia, ib;
    ia = int'(fa);
    ib = int'(fb);
    e.op = f_op; e.res = 8'h00; e.rem = 8'h00; e.err = 1'b0;
    case (f_op)
      2'd0: e.res = 8'(ia + ib);
      2'd1: e.res = 8'(ia - ib);
      2'd2: e.res = 8'(ia * ib);
      default: begin
        if (ib == 0) begin
          e.res = 8'hFF; e.rem = 8'(ia); e.err = 1'b1;
        end else begin
          e.res = 8'(ia / ib); e.rem = 8'(ia % ib);
        end
      end
    endcase
    return e;
  endfunction

  function automatic logic [18:0] exp_head();
    if (q.size() == 0) return '0;
    return {q[0].op, q[0].res, q[0].rem, q[0].err};
  endfunction

  // Present one operation as the arithmetic unit would.
  task automatic drive(input logic [1:0] d_op, input logic [3:0] da, input logic [3:0] db);
    int ia, ib;
    ia = int'(da); ib = int'(db);
    op = d_op; a = da; b = db;
    o  = 8'(ia + ib);
    o1 = 8'(ia - ib);
    o2 = 8'(ia * ib);
    o3 = (ib != 0) ? 8'(ia / ib) : 8'($urandom);
    o4 = (ib != 0) ? 8'(ia % ib) : 8'($urandom);
  endtask

  task automatic drive_random();
    logic [1:0] r_op;
    logic [3:0] ra, rb;
    r_op = 2'($urandom_range(0, 3));
    ra   = 4'($urandom_range(0, 15));
    rb   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    drive(r_op, ra, rb);
  endtask

  // Advance one clock and apply the handshake rules to the model.
  task automatic tick();
    bit   push, pop;
    exp_t e;
    push = in_valid && (q.size() < DEPTH);
    pop  = out_ready && (q.size() > 0);
    if (pop) dut_popped.push_back(out_res);
    @(posedge clk);
    if (pop) begin
      mdl_popped.push_back(q[0].res);
      void'(q.pop_front());
    end
    if (push) begin
      e = model_entry(op, a, b);
      q.push_back(e);
      if (e.err && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    q.delete(); m_cnt = 0;
    dut_popped.delete(); mdl_popped.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_op, out_res, out_rem, out_err} !== 20'h0) begin
      bad++; $display("FAIL reset_async_out: got %h want 0", {out_valid, out_op, out_res, out_rem, out_err});
    end
    total++;
    if (err_cnt !== '0) begin
      bad++; $display("FAIL reset_async_cnt: got %0d want 0", err_cnt);
    end
    q.delete(); m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    total++;
    if ({out_valid, out_op, out_res, out_rem, out_err} !== 20'h0) begin
      bad++; $display("FAIL reset_idle_out: got %h want 0", {out_valid, out_op, out_res, out_rem, out_err});
    end
    total++;
    if (err_cnt !== '0) begin
      bad++; $display("FAIL reset_idle_cnt: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_mul();
    drive(2'd2, 4'd6, 4'd7);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_op, out_res, out_rem, out_err} !== {1'b1, 2'd2, 8'd42, 8'd0, 1'b0}) begin
      bad++; $display("FAIL mul_head: got v=%b op=%0d res=%0d rem=%0d err=%b want v=1 op=2 res=42 rem=0 err=0",
                      out_valid, out_op, out_res, out_rem, out_err);
    end
    tick();
    total++;
    if ({out_valid, out_op, out_res, out_rem, out_err} !== 20'h0) begin
      bad++; $display("FAIL mul_drained: got %h want 0", {out_valid, out_op, out_res, out_rem, out_err});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_div();
    out_ready = 1'b0; in_valid = 1'b1;
    drive(2'd3, 4'd9, 4'd3);
    tick();
    drive(2'd3, 4'd7, 4'd0);
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_op, out_res, out_rem, out_err} !== {2'd3, 8'd3, 8'd0, 1'b0}) begin
      bad++; $display("FAIL div_first: got op=%0d res=%h rem=%h err=%b want op=3 res=03 rem=00 err=0",
                      out_op, out_res, out_rem, out_err);
    end
    total++;
    if (err_cnt !== 8'd1) begin
      bad++; $display("FAIL div_cnt: got %0d want 1", err_cnt);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, out_op, out_res, out_rem, out_err} !== {1'b1, 2'd3, 8'hFF, 8'h07, 1'b1}) begin
      bad++; $display("FAIL div0_entry: got v=%b op=%0d res=%h rem=%h err=%b want v=1 op=3 res=ff rem=07 err=1",
                      out_valid, out_op, out_res, out_rem, out_err);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL div_drained: got %b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    dut_popped.delete(); mdl_popped.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    drive(2'd0, 4'd2, 4'd3);
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_ready_1: got %b want 1", in_ready);
    end
    drive(2'd1, 4'd5, 4'd3);
    tick();
    drive(2'd2, 4'd3, 4'd4);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({in_ready, out_valid, out_res} !== {1'b0, 1'b1, 8'd5}) begin
        bad++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b res=%0d want rdy=0 v=1 res=5",
                        i, in_ready, out_valid, out_res);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({in_ready, out_res} !== {1'b1, 8'd2}) begin
      bad++; $display("FAIL stall_after_pop: got rdy=%b res=%0d want rdy=1 res=2", in_ready, out_res);
    end
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (dut_popped.size() != 3 || dut_popped[0] !== 8'd5 || dut_popped[1] !== 8'd2 ||
        dut_popped[2] !== 8'd12 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_order: got n=%0d v=%b want 5,2,12 then empty", dut_popped.size(), out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int mism;
    dut_popped.delete(); mdl_popped.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_random();
      tick();
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_full: in_ready got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_random();
      tick();
      total++;
      if ({in_ready, out_valid, out_op, out_res, out_rem, out_err} !== {1'b1, 1'b1, exp_head()}) begin
        bad++; $display("FAIL b2b_cycle[%0d]: got %h want %h", i,
                        {in_ready, out_valid, out_op, out_res, out_rem, out_err}, {1'b1, 1'b1, exp_head()});
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) tick();
    mism = 0;
    for (int i = 0; i < mdl_popped.size(); i++)
      if (i >= dut_popped.size() || dut_popped[i] !== mdl_popped[i]) mism++;
    total++;
    if (mism != 0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_order: got %0d differing pops, out_valid=%b want 0 differing, 0", mism, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive_random();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      total++;
      if (in_ready !== (q.size() < DEPTH)) begin
        bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, q.size() < DEPTH);
      end
      total++;
      if ({out_valid, out_op, out_res, out_rem, out_err} !== {q.size() > 0, exp_head()}) begin
        bad++; $display("FAIL rnd_head[%0d]: got %h want %h", i,
                        {out_valid, out_op, out_res, out_rem, out_err}, {q.size() > 0, exp_head()});
      end
      total++;
      if (err_cnt !== CNT_W'(m_cnt)) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, err_cnt, m_cnt);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_sat_and_reset();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(2'd3, 4'($urandom_range(0, 15)), 4'd0);
      tick();
      total++;
      if (err_cnt !== CNT_W'(m_cnt)) begin
        bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, err_cnt, m_cnt);
      end
    end
    total++;
    if (err_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_final: got %0d want 255", err_cnt);
    end
    out_ready = 1'b0;
    drive(2'd3, 4'd4, 4'd0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, err_cnt} !== 9'h0) begin
      bad++; $display("FAIL midreset_async: got v=%b cnt=%0d want v=0 cnt=0", out_valid, err_cnt);
    end
    in_valid = 1'b0;
    q.delete(); m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    total++;
    if ({in_ready, out_valid, out_op, out_res, out_rem, out_err, err_cnt} !== {1'b1, 20'h0, 8'h0}) begin
      bad++; $display("FAIL midreset_after: got rdy=%b v=%b res=%h cnt=%0d want rdy=1 v=0 res=00 cnt=0",
                      in_ready, out_valid, out_res, err_cnt);
    end
  endtask

  initial begin
    m_cnt = 0;
    test_reset();
    test_mul();
    test_div();
    test_stall();
    test_back_to_back();
    test_random();
    test_sat_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
